regfile_mp: RTL and testbench

Parametrised successor to the single-cycle register file for the multicycle/pipelined core. It provides three combinational read ports and two independently enabled write ports (ALU result and load/writeback-address). It also holds a per-register busy scoreboard so issue logic can stall on in-flight writes. The PC index is not stored; reads of it return the externally supplied r15.

---
 rtl/regfile_mp.sv | 163 ++++++++++++++++
 tb/tb_regfile_mp.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port register file with issue scoreboard.
//
// Purpose:
//   Provides three combinational read ports and two independently enabled
//   write ports. Port 3 carries ALU results and port 4 carries load or
//   writeback-address results.
//   A per-register busy bit lets issue logic stall on in-flight writes.
//   The PC index (PC_IDX) is not stored. Reads of it return the external r15.
//
// Parameters:
//   WIDTH   data width of every register and port
//   NREGS   architectural register count including the PC index (power of 2, >= 4)
//   AW      address width, derived from NREGS (do not override)
//   PC_IDX  index mapped to r15, never stored
//
// Ports:
//   clk                  clock; every state update happens on its rising edge
//   reset                asynchronous, active-low clear of all state
//   we3/wa3/wd3          write port 3: enable, address, data
//   we4/wa4/wd4          write port 4: enable, address, data
//                        (port 4 wins on an address clash)
//   ra1/ra2/ra3          read addresses
//   r15                  PC+8 value returned for reads of PC_IDX
//   lock_en/lock_addr    mark a register busy (issued with a pending write)
//   rd1/rd2/rd3          read data
//   busy1/busy2/busy3    busy bit of the addressed register
//   wr_conflict          registered: previous edge had we3 & we4 to one address
//   pc_wr_err            registered: previous edge tried a write or lock to PC_IDX
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When the macro is defined, an enabled write whose address matches a read
//   address is forwarded to that read port in the same cycle.
//   Port 4 wins when both write ports match.
//   The forwarded read reports not-busy unless the same register is being
//   locked this cycle.
//   When the macro is undefined, reads return stored values only.

module regfile_mp #(
  parameter  int WIDTH  = 32,
  parameter  int NREGS  = 16,
  localparam int AW     = $clog2(NREGS),
  localparam int PC_IDX = NREGS - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    ra3,
  input  logic [WIDTH-1:0] r15,
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic             busy1,
  output logic             busy2,
  output logic             busy3,
  output logic             wr_conflict,
  output logic             pc_wr_err
);

  localparam logic [AW-1:0] PC_ADDR = AW'(PC_IDX);

  // The array is full-size so that any AW-bit address indexes it safely.
  // The PC_IDX entry is never written, so it holds its reset value of zero.
  // It is never observed, because reads of PC_IDX are replaced by r15.
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic             wr_conflict_q;
  logic             pc_wr_err_q;

  // Each enable gates its address compare.
  // An X address therefore cannot disturb state while the enable is low.
  logic wr3_ok, wr4_ok, lock_ok;
  assign wr3_ok  = we3     && (wa3       != PC_ADDR);
  assign wr4_ok  = we4     && (wa4       != PC_ADDR);
  assign lock_ok = lock_en && (lock_addr != PC_ADDR);

  // ---------------------------------------------------------------------
  // Storage and scoreboard
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only.
  // All entries then update together from the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage array is reset on purpose. The reset state
      // requires every register to read zero, which is not a
      // "don't care" initial value.
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
      pc_wr_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        // Port 4 is tested first so it wins a same-address clash.
        if (wr4_ok && (wa4 == AW'(i)))      rf_q[i] <= wd4;
        else if (wr3_ok && (wa3 == AW'(i))) rf_q[i] <= wd3;

        // A new lock supersedes a completing write to the same register.
        if (lock_ok && (lock_addr == AW'(i)))
          busy_q[i] <= 1'b1;
        else if ((wr3_ok && (wa3 == AW'(i))) || (wr4_ok && (wa4 == AW'(i))))
          busy_q[i] <= 1'b0;
      end

      wr_conflict_q <= we3 && we4 && (wa3 == wa4);
      pc_wr_err_q   <= (we3     && (wa3       == PC_ADDR)) ||
                       (we4     && (wa4       == PC_ADDR)) ||
                       (lock_en && (lock_addr == PC_ADDR));
    end
  end

  assign wr_conflict = wr_conflict_q;
  assign pc_wr_err   = pc_wr_err_q;

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  logic [AW-1:0]    ra     [3];
  logic [WIDTH-1:0] rd     [3];
  logic             rd_bsy [3];

  assign ra[0] = ra1;
  assign ra[1] = ra2;
  assign ra[2] = ra3;

  always_comb begin
    for (int m = 0; m < 3; m++) begin
      // NOTE: every output of this block gets a default first.
      // A path that skips an assignment would otherwise infer a latch.
      rd[m]     = rf_q[ra[m]];
      rd_bsy[m] = busy_q[ra[m]];
`ifdef REGFILE_BYPASS_EN
      // Forward the value being written this cycle. Port 4 is applied last
      // so it wins. A matching lock keeps the stored busy state, because a
      // newer in-flight op is being issued to the same register.
      if (wr3_ok && (wa3 == ra[m])) rd[m] = wd3;
      if (wr4_ok && (wa4 == ra[m])) rd[m] = wd4;
      if (((wr3_ok && (wa3 == ra[m])) || (wr4_ok && (wa4 == ra[m]))) &&
          !(lock_en && (lock_addr == ra[m])))
        rd_bsy[m] = 1'b0;
`endif
      if (ra[m] == PC_ADDR) begin
        rd[m]     = r15;
        rd_bsy[m] = 1'b0;
      end
    end
  end

  assign rd1   = rd[0];
  assign rd2   = rd[1];
  assign rd3   = rd[2];
  assign busy1 = rd_bsy[0];
  assign busy2 = rd_bsy[1];
  assign busy3 = rd_bsy[2];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed self-checking bench for regfile_mp
// (default parameters: WIDTH=32, NREGS=16).
// The expected values are hand-computed constants. Where the optional
// REGFILE_BYPASS_EN forwarding changes an answer, the bench selects the
// matching constant.

module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3, we4, lock_en;
  logic [3:0]  wa3, wa4, ra1, ra2, ra3, lock_addr;
  logic [31:0] wd3, wd4, r15;
  logic [31:0] rd1, rd2, rd3;
  logic        busy1, busy2, busy3, wr_conflict, pc_wr_err;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.WIDTH(32), .NREGS(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .we4         (we4),
    .wa4         (wa4),
    .wd4         (wd4),
    .ra1         (ra1),
    .ra2         (ra2),
    .ra3         (ra3),
    .r15         (r15),
    .lock_en     (lock_en),
    .lock_addr   (lock_addr),
    .rd1         (rd1),
    .rd2         (rd2),
    .rd3         (rd3),
    .busy1       (busy1),
    .busy2       (busy2),
    .busy3       (busy3),
    .wr_conflict (wr_conflict),
    .pc_wr_err   (pc_wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle inputs/outputs away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0; we4 = 1'b0; lock_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    wa3 = '0; wa4 = '0; wd3 = '0; wd4 = '0; lock_addr = '0;
    ra1 = 4'd0; ra2 = 4'd5; ra3 = 4'd14; r15 = 32'h108;

    // Reset state
    repeat (3) tick();
    check("rst_rd1",   rd1, 32'h0);
    check("rst_rd2",   rd2, 32'h0);
    check("rst_rd3",   rd3, 32'h0);
    check("rst_busy",  {29'b0, busy1, busy2, busy3}, 32'h0);
    check("rst_wrc",   {31'b0, wr_conflict}, 32'h0);
    check("rst_pcerr", {31'b0, pc_wr_err}, 32'h0);
    reset = 1'b1;
    ra1 = 4'd15;
    #1;
    check("pc_read", rd1, 32'h108);

    // Dual write, different addresses
    we3 = 1'b1; wa3 = 4'd2; wd3 = 32'hAAAA_0001;
    we4 = 1'b1; wa4 = 4'd7; wd4 = 32'h5555_000F;
    ra1 = 4'd2; ra2 = 4'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("pre_edge_rd1", rd1, 32'hAAAA_0001);
`else
    check("pre_edge_rd1", rd1, 32'h0);
`endif
    tick(); idle();
    check("dual_rd1", rd1, 32'hAAAA_0001);
    check("dual_rd2", rd2, 32'h5555_000F);
    check("dual_wrc", {31'b0, wr_conflict}, 32'h0);

    // Same-address conflict: port 4 wins, flag for one cycle
    we3 = 1'b1; we4 = 1'b1; wa3 = 4'd4; wa4 = 4'd4; wd3 = 32'h11; wd4 = 32'h22;
    ra3 = 4'd4;
    tick(); idle();
    check("conf_rd",   rd3, 32'h22);
    check("conf_wrc1", {31'b0, wr_conflict}, 32'h1);
    tick();
    check("conf_wrc0", {31'b0, wr_conflict}, 32'h0);

    // Single port 3 write leaves port-4 data untouched
    we3 = 1'b1; wa3 = 4'd7; wd3 = 32'hCAFE_0007;
    tick(); idle();
    check("p3_only", rd2, 32'hCAFE_0007);

    // Scoreboard
    ra1 = 4'd9; ra2 = 4'd8;
    lock_en = 1'b1; lock_addr = 4'd9;
    tick(); idle();
    check("lock_busy",  {31'b0, busy1}, 32'h1);
    check("other_free", {31'b0, busy2}, 32'h0);
    we3 = 1'b1; wa3 = 4'd9; wd3 = 32'h99;
    tick(); idle();
    check("wr_clears", {31'b0, busy1}, 32'h0);
    check("wr_data9",  rd1, 32'h99);
    lock_en = 1'b1; lock_addr = 4'd9; we4 = 1'b1; wa4 = 4'd9; wd4 = 32'h98;
    tick(); idle();
    check("lock_wins", {31'b0, busy1}, 32'h1);
    check("lock_wr_d", rd1, 32'h98);

    // Write to PC index: ignored, flag one cycle
    ra1 = 4'd15; r15 = 32'h200;
    we4 = 1'b1; wa4 = 4'd15; wd4 = 32'hDEAD;
    tick(); idle();
    check("pc_rd",    rd1, 32'h200);
    check("pc_busy",  {31'b0, busy1}, 32'h0);
    check("pc_err1",  {31'b0, pc_wr_err}, 32'h1);
    tick();
    check("pc_err0",  {31'b0, pc_wr_err}, 32'h0);
    lock_en = 1'b1; lock_addr = 4'd15;
    tick(); idle();
    check("pc_lock_err", {31'b0, pc_wr_err}, 32'h1);

    // Same-cycle read of a write in progress
    we3 = 1'b1; wa3 = 4'd3; wd3 = 32'h1234; ra1 = 4'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_pre", rd1, 32'h1234);
`else
    check("byp_pre", rd1, 32'h0);
`endif
    tick(); idle();
    check("byp_post", rd1, 32'h1234);

    // Asynchronous reset mid-run clears without a clock edge
    ra1 = 4'd2; ra2 = 4'd9;
    #2 reset = 1'b0;
    #1;
    check("async_rd", rd1, 32'h0);
    check("async_busy", {31'b0, busy2}, 32'h0);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
